// File: rtl/parallel2serial_tx.sv
// parallel2serial_tx: buffers 4-bit words in a small FIFO and sends them as
// continuous 4-bit groups on srl, LSB first, one bit per clk. The group
// phase starts at reset release. When no word is ready at a group boundary,
// the module sends IDLE_WORD so the downstream 4-cycle demux stays aligned.
// Optional feature macro: P2S_UNDERRUN_CNT_EN adds a saturating count of
// idle groups caused by an empty FIFO.
module parallel2serial_tx #(
  parameter int         FIFO_DEPTH = 4,
  parameter logic [3:0] IDLE_WORD  = 4'b0000
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [3:0]                    in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic                          srl,
  output logic                          sym_start,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
`ifdef P2S_UNDERRUN_CNT_EN
  ,
  output logic [7:0]                    underrun_cnt
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL_LEVEL = LW'(FIFO_DEPTH);

  logic [3:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wrPtr_q, wrPtr_d;
  logic [AW-1:0] rdPtr_q, rdPtr_d;
  logic [LW-1:0] level_q, level_d;
  logic [1:0]    ph_q, ph_d;
  logic [3:0]    sh_q, sh_d;
  logic          srl_q, srl_d;

  logic          push;
  logic          pop;
  logic          fifoEmpty;
  logic [3:0]    headWord;

  // A word written at a phase-3 edge is not yet in level_q, so it cannot be
  // popped at that same edge; that group goes out idle instead.
  assign fifoEmpty = (level_q == '0);
  assign in_ready  = (level_q != FULL_LEVEL);
  assign push      = in_valid && in_ready;
  assign pop       = (ph_q == 2'd3) && !fifoEmpty;
  assign headWord  = mem_q[rdPtr_q];

  assign srl        = srl_q;
  assign sym_start  = (ph_q == 2'd0);
  assign fifo_level = level_q;

  // FIFO pointer and occupancy bookkeeping. Level is kept separately so
  // that full and empty are never confused when the pointers are equal.
  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    level_d = level_q;
    if (push) begin
      wrPtr_d = wrPtr_q + AW'(1);
    end
    if (pop) begin
      rdPtr_d = rdPtr_q + AW'(1);
    end
    case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  // Phase sequencing: step through the current group, then load the next
  // word (or the idle word) at the last bit of the group.
  always_comb begin
    ph_d  = ph_q + 2'd1;
    sh_d  = sh_q;
    srl_d = sh_q[ph_q + 2'd1];
    if (ph_q == 2'd3) begin
      if (pop) begin
        sh_d  = headWord;
        srl_d = headWord[0];
      end else begin
        sh_d  = IDLE_WORD;
        srl_d = IDLE_WORD[0];
      end
    end
  end

  // Control and datapath registers; reset discards any queued words and
  // restarts with an idle group at phase 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      level_q <= '0;
      ph_q    <= 2'd0;
      sh_q    <= IDLE_WORD;
      srl_q   <= IDLE_WORD[0];
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      level_q <= level_d;
      ph_q    <= ph_d;
      sh_q    <= sh_d;
      srl_q   <= srl_d;
    end
  end

  // FIFO storage; contents need no reset because level_q governs validity.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wrPtr_q] <= in_data;
    end
  end

`ifdef P2S_UNDERRUN_CNT_EN
  logic [7:0] underrun_q, underrun_d;

  assign underrun_cnt = underrun_q;

  // Count group boundaries that had to fall back to the idle word,
  // saturating so that long idle stretches never wrap to a small value.
  always_comb begin
    underrun_d = underrun_q;
    if ((ph_q == 2'd3) && fifoEmpty && (underrun_q != 8'hFF)) begin
      underrun_d = underrun_q + 8'd1;
    end
  end

  // Underrun counter register, cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      underrun_q <= 8'd0;
    end else begin
      underrun_q <= underrun_d;
    end
  end
`endif

endmodule
